// File: rtl/uart_reg_bridge_pkg.sv
// Command characters, reserved addresses and state encodings shared by the
// UART register bridge and its serial engine.
package uart_reg_bridge_pkg;

    localparam logic [7:0] CMD_MARK    = 8'h6D;
    localparam logic [7:0] CMD_WRITE   = 8'h77;
    localparam logic [7:0] CMD_READ    = 8'h72;
    localparam logic [7:0] STATUS_ADDR = 8'hFF;

    typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} serState_e;
    typedef enum logic [1:0] {PAR_IDLE, PAR_EXEC, PAR_WAIT_TX} parState_e;

    // Returns {isHex, nibble}; both letter cases share the same low-nibble offset.
    function automatic logic [4:0] hexDecode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Byte-level handshake between the serial engine (slave) and the command parser (master).
interface uart_reg_bridge_if;

    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxReady;
    logic [7:0] txByte;
    logic       txValid;
    logic       txReady;
    logic       frameErr;
    logic       overrunErr;

    modport master (
        input  rxByte, rxValid, txReady, frameErr, overrunErr,
        output rxReady, txByte, txValid
    );

    modport slave (
        output rxByte, rxValid, txReady, frameErr, overrunErr,
        input  rxReady, txByte, txValid
    );

endinterface

// File: rtl/uart_reg_bridge_uart.sv
// 8N1 serial engine: free-running 16x baud tick, receiver with a one-byte hold,
// and a transmitter that starts its frame on the first tick after a load.
module uart_8n1 #(
    parameter int BAUD_DIV = 21
) (
    input  logic clk,
    input  logic reset_n,
    input  logic uart_rx,
    output logic uart_tx,
    uart_reg_bridge_if.slave bus
);
    import uart_reg_bridge_pkg::*;

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] baudCnt_q;
    logic          tick;
    logic [1:0]    rxSync_q;
    logic          rxPrev_q, rxIn;
    serState_e     rxState_q, rxState_d, txState_q, txState_d;
    logic [3:0]    rxTicks_q, rxTicks_d, txTicks_q, txTicks_d;
    logic [2:0]    rxBits_q, rxBits_d, txBits_q, txBits_d;
    logic [7:0]    rxShift_q, rxShift_d, hold_q, hold_d, txShift_q, txShift_d;
    logic          holdFull_q, holdFull_d, txPend_q, txPend_d, txLine_q, txLine_d;

    assign tick        = (baudCnt_q == CW'(BAUD_DIV - 1));
    assign rxIn        = rxSync_q[1];
    assign uart_tx     = txLine_q;
    assign bus.rxByte  = hold_q;
    assign bus.rxValid = holdFull_q;
    assign bus.txReady = (txState_q == SER_IDLE) && !txPend_q;

    always_comb begin
        rxState_d      = rxState_q;
        rxTicks_d      = rxTicks_q;
        rxBits_d       = rxBits_q;
        rxShift_d      = rxShift_q;
        hold_d         = hold_q;
        holdFull_d     = holdFull_q && !bus.rxReady;
        bus.frameErr   = 1'b0;
        bus.overrunErr = 1'b0;
        case (rxState_q)
            SER_IDLE: begin
                if (rxPrev_q && !rxIn) begin
                    rxState_d = SER_START;
                    rxTicks_d = '0;
                end
            end
            SER_START: begin
                if (tick) begin
                    rxTicks_d = rxTicks_q + 4'd1;
                    if (rxTicks_q == 4'd7) begin
                        rxTicks_d = '0;
                        rxBits_d  = '0;
                        rxState_d = rxIn ? SER_IDLE : SER_DATA;
                    end
                end
            end
            SER_DATA: begin
                if (tick) begin
                    rxTicks_d = rxTicks_q + 4'd1;
                    if (rxTicks_q == 4'd15) begin
                        rxShift_d = {rxIn, rxShift_q[7:1]};
                        rxBits_d  = rxBits_q + 3'd1;
                        if (rxBits_q == 3'd7) rxState_d = SER_STOP;
                    end
                end
            end
            SER_STOP: begin
                if (tick) begin
                    rxTicks_d = rxTicks_q + 4'd1;
                    if (rxTicks_q == 4'd15) begin
                        rxState_d = SER_IDLE;
                        if (!rxIn) begin
                            bus.frameErr = 1'b1;
                        end else if (holdFull_q) begin
                            bus.overrunErr = 1'b1;
                        end else begin
                            hold_d     = rxShift_q;
                            holdFull_d = 1'b1;
                        end
                    end
                end
            end
            default: rxState_d = SER_IDLE;
        endcase
    end

    // A load only arms the frame; the start bit waits for the next baud tick.
    always_comb begin
        txState_d = txState_q;
        txTicks_d = txTicks_q;
        txBits_d  = txBits_q;
        txShift_d = txShift_q;
        txPend_d  = txPend_q;
        txLine_d  = 1'b1;
        case (txState_q)
            SER_IDLE: begin
                if (bus.txValid && !txPend_q) begin
                    txShift_d = bus.txByte;
                    txPend_d  = 1'b1;
                end else if (txPend_q && tick) begin
                    txPend_d  = 1'b0;
                    txTicks_d = '0;
                    txState_d = SER_START;
                end
            end
            SER_START: begin
                if (tick) begin
                    txTicks_d = txTicks_q + 4'd1;
                    if (txTicks_q == 4'd15) begin
                        txBits_d  = '0;
                        txState_d = SER_DATA;
                    end
                end
            end
            SER_DATA: begin
                if (tick) begin
                    txTicks_d = txTicks_q + 4'd1;
                    if (txTicks_q == 4'd15) begin
                        txShift_d = {1'b1, txShift_q[7:1]};
                        txBits_d  = txBits_q + 3'd1;
                        if (txBits_q == 3'd7) txState_d = SER_STOP;
                    end
                end
            end
            SER_STOP: begin
                if (tick) begin
                    txTicks_d = txTicks_q + 4'd1;
                    if (txTicks_q == 4'd15) txState_d = SER_IDLE;
                end
            end
            default: txState_d = SER_IDLE;
        endcase
        case (txState_d)
            SER_START: txLine_d = 1'b0;
            SER_DATA:  txLine_d = txShift_d[0];
            default:   txLine_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baudCnt_q  <= '0;
            rxSync_q   <= 2'b11;
            rxPrev_q   <= 1'b1;
            rxState_q  <= SER_IDLE;
            rxTicks_q  <= '0;
            rxBits_q   <= '0;
            rxShift_q  <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            txState_q  <= SER_IDLE;
            txTicks_q  <= '0;
            txBits_q   <= '0;
            txShift_q  <= '0;
            txPend_q   <= 1'b0;
            txLine_q   <= 1'b1;
        end else begin
            baudCnt_q  <= tick ? '0 : baudCnt_q + CW'(1);
            rxSync_q   <= {rxSync_q[0], uart_rx};
            rxPrev_q   <= rxIn;
            rxState_q  <= rxState_d;
            rxTicks_q  <= rxTicks_d;
            rxBits_q   <= rxBits_d;
            rxShift_q  <= rxShift_d;
            hold_q     <= hold_d;
            holdFull_q <= holdFull_d;
            txState_q  <= txState_d;
            txTicks_q  <= txTicks_d;
            txBits_q   <= txBits_d;
            txShift_q  <= txShift_d;
            txPend_q   <= txPend_d;
            txLine_q   <= txLine_d;
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// ASCII command parser and register file driven over an 8N1 serial link:
// hex digits build acc, 'm' sets addr, 'w' writes a port, 'r' reads one back.
module uart_reg_bridge #(
    parameter int                   N_PORTS   = 48,
    parameter int                   BAUD_DIV  = 21,
    parameter logic [8*N_PORTS-1:0] RESET_VAL = '0,
    parameter int                   AUTO_INC  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   uart_rx,
    output logic                   uart_tx,
    output logic [8*N_PORTS-1:0]   out_ports,
    output logic [N_PORTS-1:0]     out_stb,
    input  logic [8*N_PORTS-1:0]   in_ports,
    output logic [N_PORTS-1:0]     rd_stb
);
    import uart_reg_bridge_pkg::*;

    uart_reg_bridge_if bus ();

    parState_e            parState_q, parState_d;
    logic [7:0]           cmd_q, cmd_d, acc_q, acc_d, addr_q, addr_d;
    logic [8*N_PORTS-1:0] ports_q, ports_d;
    logic [N_PORTS-1:0]   outStb_q, outStb_d, rdStb_q, rdStb_d;
    logic [1:0]           status_q, status_d, statusPend_q, statusPend_d, errs;
    logic                 statusClr;
    logic [4:0]           nib;

    uart_8n1 #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .reset_n (reset_n),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .bus     (bus)
    );

    assign nib       = hexDecode(cmd_q);
    assign out_ports = ports_q;
    assign out_stb   = outStb_q;
    assign rd_stb    = rdStb_q;

    // A read stalls in the hold until the transmitter can accept its byte.
    always_comb begin
        parState_d  = parState_q;
        cmd_d       = cmd_q;
        acc_d       = acc_q;
        addr_d      = addr_q;
        ports_d     = ports_q;
        outStb_d    = '0;
        rdStb_d     = '0;
        statusClr   = 1'b0;
        bus.rxReady = 1'b0;
        bus.txValid = 1'b0;
        bus.txByte  = 8'hFF;
        case (parState_q)
            PAR_IDLE: begin
                if (bus.rxValid) begin
                    if (bus.rxByte == CMD_READ && !bus.txReady) begin
                        parState_d = PAR_WAIT_TX;
                    end else begin
                        bus.rxReady = 1'b1;
                        cmd_d       = bus.rxByte;
                        parState_d  = PAR_EXEC;
                    end
                end
            end
            PAR_WAIT_TX: begin
                if (bus.txReady) begin
                    bus.rxReady = 1'b1;
                    cmd_d       = bus.rxByte;
                    parState_d  = PAR_EXEC;
                end
            end
            PAR_EXEC: begin
                parState_d = PAR_IDLE;
                if (nib[4]) begin
                    acc_d = {acc_q[3:0], nib[3:0]};
                end else if (cmd_q == CMD_MARK) begin
                    addr_d = acc_q;
                end else if (cmd_q == CMD_WRITE) begin
                    for (int k = 0; k < N_PORTS; k++) begin
                        if (addr_q == 8'(k)) begin
                            ports_d[8*k +: 8] = acc_q;
                            outStb_d[k]       = 1'b1;
                        end
                    end
                    if (AUTO_INC != 0) addr_d = addr_q + 8'd1;
                end else if (cmd_q == CMD_READ) begin
                    bus.txValid = 1'b1;
                    if (addr_q == STATUS_ADDR) begin
                        bus.txByte = {6'b0, status_q};
                        statusClr  = 1'b1;
                    end
                    for (int k = 0; k < N_PORTS; k++) begin
                        if (addr_q == 8'(k)) begin
                            bus.txByte = in_ports[8*k +: 8];
                            rdStb_d[k] = 1'b1;
                        end
                    end
                    if (AUTO_INC != 0) addr_d = addr_q + 8'd1;
                end
            end
            default: parState_d = PAR_IDLE;
        endcase
    end

    // An error arriving with a status read is deferred one clk so the clear wins.
    always_comb begin
        errs = {bus.overrunErr, bus.frameErr};
        if (statusClr) begin
            status_d     = '0;
            statusPend_d = errs;
        end else begin
            status_d     = status_q | statusPend_q | errs;
            statusPend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parState_q   <= PAR_IDLE;
            cmd_q        <= '0;
            acc_q        <= '0;
            addr_q       <= '0;
            ports_q      <= RESET_VAL;
            outStb_q     <= '0;
            rdStb_q      <= '0;
            status_q     <= '0;
            statusPend_q <= '0;
        end else begin
            parState_q   <= parState_d;
            cmd_q        <= cmd_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            ports_q      <= ports_d;
            outStb_q     <= outStb_d;
            rdStb_q      <= rdStb_d;
            status_q     <= status_d;
            statusPend_q <= statusPend_d;
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Drives ASCII command strings over the serial line and compares ports, strobes
// and transmitted bytes with a character-level model of the bridge.
module tb_uart_reg_bridge;

    localparam int N        = 48;
    localparam int BAUD_DIV = 2;
    localparam int BITCLK   = 16 * BAUD_DIV;
    localparam logic [8*N-1:0] RV = {{(8*N-24){1'b0}}, 24'hA5_4000};

    logic           clk;
    logic           reset_n;
    logic           uart_rx;
    logic           uart_tx;
    logic [8*N-1:0] out_ports;
    logic [N-1:0]   out_stb;
    logic [8*N-1:0] inPorts;
    logic [N-1:0]   rd_stb;

    logic [7:0] mPorts [N];
    logic [7:0] mAcc, mAddr;
    logic [1:0] mStatus;
    logic [7:0] expTx [$];
    logic [8:0] gotTx [$];
    int         expOut [N], expRd [N], obsOut [N], obsRd [N];
    logic       multiHot;
    int         checks, passed, failed;

    uart_reg_bridge #(
        .N_PORTS   (N),
        .BAUD_DIV  (BAUD_DIV),
        .RESET_VAL (RV),
        .AUTO_INC  (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .out_ports (out_ports),
        .out_stb   (out_stb),
        .in_ports  (inPorts),
        .rd_stb    (rd_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (out_stb[k] === 1'b1) obsOut[k]++;
            if (rd_stb[k] === 1'b1) obsRd[k]++;
        end
        if ($countones(out_stb) > 1 || $countones(rd_stb) > 1) multiHot = 1'b1;
    end

    // Serial receiver on uart_tx: sample each bit near its centre, stop bit in bit 8.
    initial begin : txMon
        logic [8:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                repeat (BITCLK / 2) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    repeat (BITCLK) @(negedge clk);
                    b[i] = uart_tx;
                end
                gotTx.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < N; k++) mPorts[k] = RV[8*k +: 8];
        mAcc    = 8'h00;
        mAddr   = 8'h00;
        mStatus = 2'b00;
    endtask

    task automatic modelChar(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            mAcc = {mAcc[3:0], 4'(c - 8'h30)};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            mAcc = {mAcc[3:0], 4'(c - 8'h61 + 8'd10)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            mAcc = {mAcc[3:0], 4'(c - 8'h41 + 8'd10)};
        end else if (c == 8'h6D) begin
            mAddr = mAcc;
        end else if (c == 8'h77) begin
            if (int'(mAddr) < N) begin
                mPorts[mAddr] = mAcc;
                expOut[mAddr]++;
            end
            mAddr = mAddr + 8'd1;
        end else if (c == 8'h72) begin
            if (int'(mAddr) < N) begin
                expTx.push_back(inPorts[8*int'(mAddr) +: 8]);
                expRd[mAddr]++;
            end else if (mAddr == 8'hFF) begin
                expTx.push_back({6'b0, mStatus});
                mStatus = 2'b00;
            end else begin
                expTx.push_back(8'hFF);
            end
            mAddr = mAddr + 8'd1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        uart_rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BITCLK) @(negedge clk);
        end
        uart_rx = stopBit;
        repeat (BITCLK) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            sendFrame(s[i], 1'b1);
            modelChar(s[i]);
        end
    endtask

    task automatic checkTx(input string tag);
        int budget;
        budget = 0;
        while (gotTx.size() < expTx.size() && budget < 40 * BITCLK) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, "_count"}, 64'(gotTx.size()), 64'(expTx.size()));
        while (expTx.size() > 0 && gotTx.size() > 0) begin
            checkOutput(tag, 64'(gotTx.pop_front()), 64'({1'b1, expTx.pop_front()}));
        end
        expTx.delete();
        gotTx.delete();
    endtask

    task automatic checkPort(input string tag, input int k);
        checkOutput(tag, 64'(out_ports[8*k +: 8]), 64'(mPorts[k]));
    endtask

    initial begin
        logic [7:0] a, v;
        int         op;
        checks   = 0;
        passed   = 0;
        failed   = 0;
        multiHot = 1'b0;
        reset_n  = 1'b0;
        uart_rx  = 1'b1;
        for (int k = 0; k < N; k++) begin
            expOut[k] = 0; expRd[k] = 0; obsOut[k] = 0; obsRd[k] = 0;
            inPorts[8*k +: 8] = 8'($urandom);
        end
        inPorts[8*7 +: 8] = 8'hC3;
        inPorts[8*0 +: 8] = 8'h10;
        inPorts[8*1 +: 8] = 8'h20;
        inPorts[8*2 +: 8] = 8'h30;
        modelReset();

        #12;
        checkOutput("rst_tx", 64'(uart_tx), 64'(1));
        checkOutput("rst_out_stb", 64'(out_stb), 64'(0));
        checkOutput("rst_rd_stb", 64'(rd_stb), 64'(0));
        checkPort("rst_port1", 1);
        checkPort("rst_port2", 2);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4 * BITCLK) @(negedge clk);

        applyStimulus("05m3Aw");
        checkPort("w_port5", 5);
        checkOutput("w_stb5", 64'(obsOut[5]), 64'(expOut[5]));
        checkOutput("w_addr", 64'(dut.addr_q), 64'(mAddr));

        applyStimulus("07mr");
        checkTx("r7_tx");
        checkOutput("r7_rdstb", 64'(obsRd[7]), 64'(expRd[7]));
        checkOutput("r7_addr", 64'(dut.addr_q), 64'(mAddr));

        applyStimulus("FFm11w");
        checkOutput("wff_addr", 64'(dut.addr_q), 64'(mAddr));
        applyStimulus("FFmr");
        checkTx("status_clean");
        checkOutput("rff_addr", 64'(dut.addr_q), 64'(mAddr));

        sendFrame(8'h55, 1'b0);
        mStatus[0] = 1'b1;
        repeat (BITCLK) @(negedge clk);
        applyStimulus("FFmr");
        checkTx("status_frame");
        applyStimulus("FFmr");
        checkTx("status_cleared");

        applyStimulus("00mrrr");
        checkTx("burst_tx");
        checkOutput("burst_addr", 64'(dut.addr_q), 64'(mAddr));
        applyStimulus("FFmr");
        checkTx("burst_no_overrun");

        applyStimulus("07mr");
        repeat (4 * BITCLK) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midtx_rst_tx", 64'(uart_tx), 64'(1));
        checkOutput("midtx_rst_port1", 64'(out_ports[15:8]), 64'(8'h40));
        checkOutput("midtx_rst_port5", 64'(out_ports[47:40]), 64'(RV[47:40]));
        checkOutput("midtx_rst_stb", 64'(out_stb | rd_stb), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        repeat (12 * BITCLK) @(negedge clk);
        expTx.delete();
        gotTx.delete();

        for (int it = 0; it < 8; it++) begin
            op = int'($urandom_range(0, 3));
            v  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'(N + int'($urandom_range(0, 10)));
            else a = 8'($urandom_range(0, N - 1));
            case (op)
                0: applyStimulus($sformatf("%02xm%02xw", a, v));
                1: applyStimulus($sformatf("%02Xm r", a));
                2: applyStimulus($sformatf("%02xm%02Xww", a, v));
                default: applyStimulus("FFmr");
            endcase
            checkTx($sformatf("rand%0d_tx", it));
            checkOutput($sformatf("rand%0d_addr", it), 64'(dut.addr_q), 64'(mAddr));
        end

        for (int k = 0; k < N; k++) begin
            checkPort($sformatf("final_port%0d", k), k);
            checkOutput($sformatf("final_wstb%0d", k), 64'(obsOut[k]), 64'(expOut[k]));
            checkOutput($sformatf("final_rstb%0d", k), 64'(obsRd[k]), 64'(expRd[k]));
        end
        checkOutput("onehot_strobes", 64'(multiHot), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
